// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU instruction and data memories: default widths
// and the fetch exception codes returned alongside each response.
package cpu_mem_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_RANGE    = 2'b10
  } exc_e;

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port and one synchronous,
// enable-gated read port. Contents are never reset.
module imem_array #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 64,
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // rdata only changes on a read, so it stays valid while the pipeline is frozen.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/inst_memory_pipelined.sv
// Pipelined instruction memory for the fetch stage: classifies each request, reads
// the array in stage 1, and carries the result through LATENCY frozen-on-stall stages.
module inst_memory_pipelined
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_exc,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic                  stall;
  logic                  accept;
  exc_e                  req_exc;
  logic                  ld_in_range;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  unused_ld_lsb;

  assign stall     = rsp_valid & ~rsp_ready;
  assign req_ready = rst & ~flush & ~ld_en & ~stall;
  assign accept    = req_valid & req_ready;

  // Range checks use the full byte-address width so large addresses never alias.
  always_comb begin
    if (req_addr[0]) begin
      req_exc = EXC_MISALIGN;
    end else if ({1'b0, req_addr[ADDR_WIDTH-1:1]} >= ADDR_WIDTH'(DEPTH)) begin
      req_exc = EXC_RANGE;
    end else begin
      req_exc = EXC_NONE;
    end
  end

  assign ld_in_range   = {1'b0, ld_addr[ADDR_WIDTH-1:1]} < ADDR_WIDTH'(DEPTH);
  assign mem_we        = rst & ld_en & ld_in_range;
  assign mem_re        = accept & (req_exc == EXC_NONE);
  assign unused_ld_lsb = ld_addr[0];

  imem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(ld_addr[IDX_W:1]),
    .wdata(ld_data),
    .re   (mem_re),
    .raddr(req_addr[IDX_W:1]),
    .rdata(mem_rdata)
  );

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic                  valid_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    exc_e                  exc_q;
    logic [DATA_WIDTH-1:0] data;

    if (k == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_q <= 1'b0;
          addr_q  <= '0;
          exc_q   <= EXC_NONE;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (!stall) begin
          valid_q <= accept;
          addr_q  <= req_addr;
          exc_q   <= req_exc;
        end
      end

      // Array output joins here; faulted or empty slots carry zero data.
      assign data = (valid_q && exc_q == EXC_NONE) ? mem_rdata : '0;
    end else begin : g_next
      logic [DATA_WIDTH-1:0] data_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          valid_q <= 1'b0;
          addr_q  <= '0;
          exc_q   <= EXC_NONE;
          data_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (!stall) begin
          valid_q <= g_stage[k-1].valid_q;
          addr_q  <= g_stage[k-1].addr_q;
          exc_q   <= g_stage[k-1].exc_q;
          data_q  <= g_stage[k-1].data;
        end
      end

      assign data = data_q;
    end
  end

  assign rsp_valid = g_stage[LATENCY-1].valid_q;
  assign rsp_addr  = g_stage[LATENCY-1].addr_q;
  assign rsp_exc   = g_stage[LATENCY-1].exc_q;
  assign rsp_data  = g_stage[LATENCY-1].data;

endmodule

// File: tb/tb_inst_memory_pipelined.sv
// Bench for inst_memory_pipelined: three instances (LATENCY 1, 2, 4) share stimulus and
// are checked every cycle against a queue-of-countdowns model, plus literal spot checks.
module tb_inst_memory_pipelined;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 64;
  localparam int          NDUT  = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    exc;
    logic [DW-1:0] data;
    int            rem;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst, flush, req_valid, rsp_ready, ld_en;
  logic [AW-1:0] req_addr, ld_addr;
  logic [DW-1:0] ld_data;

  logic [NDUT-1:0] req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data [NDUT];
  logic [1:0]      rsp_exc  [NDUT];
  logic [AW-1:0]   rsp_addr [NDUT];

  ent_t          fq [NDUT][8];
  int            cnt [NDUT];
  logic [DW-1:0] mem_m [DEPTH];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  inst_memory_pipelined #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data[0]), .rsp_exc(rsp_exc[0]), .rsp_addr(rsp_addr[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  inst_memory_pipelined #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(2)) dut_l2 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data[1]), .rsp_exc(rsp_exc[1]), .rsp_addr(rsp_addr[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  inst_memory_pipelined #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(4)) dut_l4 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready[2]),
    .req_addr(req_addr), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data[2]), .rsp_exc(rsp_exc[2]), .rsp_addr(rsp_addr[2]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
  endfunction

  function automatic logic [1:0] exp_exc(logic [AW-1:0] a);
    int unsigned v;
    v = 32'(a);
    if (v % 2 == 1) return 2'b01;
    if (v / 2 >= DEPTH) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each in-flight fetch counts down non-stalled cycles; the head shows at zero.
  task automatic model_step();
    for (int i = 0; i < NDUT; i++) begin
      bit   hv;
      bit   st;
      ent_t e;
      if (!rst || flush) begin
        cnt[i] = 0;
      end else begin
        hv = (cnt[i] > 0) && (fq[i][0].rem == 0);
        st = hv && !rsp_ready;
        if (!st) begin
          if (hv) begin
            for (int j = 0; j < cnt[i] - 1; j++) fq[i][j] = fq[i][j+1];
            cnt[i] = cnt[i] - 1;
          end
          for (int j = 0; j < cnt[i]; j++) fq[i][j].rem = fq[i][j].rem - 1;
          if (req_valid && !ld_en) begin
            e.addr = req_addr;
            e.exc  = exp_exc(req_addr);
            e.data = (e.exc == 2'b00) ? mem_m[req_addr / 2] : '0;
            e.rem  = lat_of(i) - 1;
            fq[i][cnt[i]] = e;
            cnt[i] = cnt[i] + 1;
          end
        end
      end
    end
    if (rst && ld_en && (32'(ld_addr) / 2 < DEPTH)) mem_m[ld_addr / 2] = ld_data;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ld(logic [AW-1:0] a, logic [DW-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    cyc();
    ld_en   = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k < 6) return AW'($urandom_range(0, DEPTH - 1) * 2);
    if (k == 6) return AW'($urandom_range(0, DEPTH - 1) * 2 + 1);
    if (k == 7) return AW'(DEPTH * 2 + $urandom_range(0, 100) * 2);
    if (k == 8) return 16'hFFFE;
    return ($urandom_range(0, 1) == 0) ? 16'h007E : 16'h0080;
  endfunction

  // Per-cycle compare of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        bit ev;
        bit er;
        ev = (cnt[i] > 0) && (fq[i][0].rem == 0);
        er = rst && !flush && !ld_en && !(ev && !rsp_ready);
        check($sformatf("rsp_valid L%0d", lat_of(i)), 32'(rsp_valid[i]), 32'(ev));
        check($sformatf("req_ready L%0d", lat_of(i)), 32'(req_ready[i]), 32'(er));
        if (ev) begin
          check($sformatf("rsp_data L%0d", lat_of(i)), 32'(rsp_data[i]), 32'(fq[i][0].data));
          check($sformatf("rsp_exc L%0d", lat_of(i)), 32'(rsp_exc[i]), 32'(fq[i][0].exc));
          check($sformatf("rsp_addr L%0d", lat_of(i)), 32'(rsp_addr[i]), 32'(fq[i][0].addr));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NDUT; i++) cnt[i] = 0;
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < NDUT; i++) begin
      check("reset rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("reset rsp_data", 32'(rsp_data[i]), 32'd0);
      check("reset rsp_exc", 32'(rsp_exc[i]), 32'd0);
      check("reset rsp_addr", 32'(rsp_addr[i]), 32'd0);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    for (int w = 0; w < int'(DEPTH); w++) ld(AW'(w * 2), DW'($urandom));

    // Back-to-back fetches of freshly loaded words.
    ld(16'h0000, 16'h012F);
    ld(16'h0002, 16'h012E);
    req_valid = 1'b1; req_addr = 16'h0000;
    cyc();
    req_addr = 16'h0002;
    cyc();
    req_valid = 1'b0;
    check("t1 L2 first valid", 32'(rsp_valid[1]), 32'd1);
    check("t1 L2 first data", 32'(rsp_data[1]), 32'h012F);
    check("t1 L2 first exc", 32'(rsp_exc[1]), 32'd0);
    cyc();
    check("t1 L2 second data", 32'(rsp_data[1]), 32'h012E);
    repeat (5) cyc();

    // Exception classes and the last in-range word.
    ld(16'h007E, 16'hA5A5);
    req_valid = 1'b1; req_addr = 16'h0003;
    cyc();
    check("t2 L1 misalign exc", 32'(rsp_exc[0]), 32'd1);
    check("t2 L1 misalign data", 32'(rsp_data[0]), 32'd0);
    req_addr = 16'h0080;
    cyc();
    check("t2 L1 range exc", 32'(rsp_exc[0]), 32'd2);
    check("t2 L1 range data", 32'(rsp_data[0]), 32'd0);
    req_addr = 16'h007E;
    cyc();
    req_valid = 1'b0;
    check("t2 L1 last word exc", 32'(rsp_exc[0]), 32'd0);
    check("t2 L1 last word data", 32'(rsp_data[0]), 32'hA5A5);
    repeat (5) cyc();

    // Stream with a three-cycle stall in the middle.
    req_valid = 1'b1; req_addr = 16'h0000;
    cyc();
    req_addr = 16'h0002;
    cyc();
    req_addr = 16'h0004; rsp_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("t3 L2 ready while stalled", 32'(req_ready[1]), 32'd0);
      check("t3 L2 held data", 32'(rsp_data[1]), 32'h012F);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    check("t3 L2 data on release", 32'(rsp_data[1]), 32'h012F);
    cyc();
    req_addr = 16'h0006;
    check("t3 L2 next in order", 32'(rsp_data[1]), 32'h012E);
    cyc();
    req_valid = 1'b0;
    repeat (8) cyc();

    // Flush with a same-cycle request.
    req_valid = 1'b1; req_addr = 16'h0008;
    cyc();
    req_addr = 16'h000A;
    cyc();
    flush = 1'b1; req_addr = 16'h000C;
    #1;
    check("t4 ready during flush", 32'(req_ready), 32'd0);
    cyc();
    flush = 1'b0; req_addr = 16'h0000;
    check("t4 L2 empty after flush", 32'(rsp_valid[1]), 32'd0);
    check("t4 L4 empty after flush", 32'(rsp_valid[2]), 32'd0);
    cyc();
    req_valid = 1'b0;
    check("t4 L4 still empty", 32'(rsp_valid[2]), 32'd0);
    cyc();
    check("t4 L2 refetch valid", 32'(rsp_valid[1]), 32'd1);
    check("t4 L2 refetch data", 32'(rsp_data[1]), 32'h012F);
    check("t4 L4 not yet", 32'(rsp_valid[2]), 32'd0);
    cyc();
    cyc();
    check("t4 L4 refetch data", 32'(rsp_data[2]), 32'h012F);
    repeat (4) cyc();

    // Load blocks the request; the next-cycle fetch sees the new word.
    ld_en = 1'b1; ld_addr = 16'h0032; ld_data = 16'hEFFF;
    req_valid = 1'b1; req_addr = 16'h0032;
    #1;
    check("t5 ready during load", 32'(req_ready), 32'd0);
    cyc();
    ld_en = 1'b0;
    cyc();
    req_valid = 1'b0;
    cyc();
    check("t5 L2 loaded word", 32'(rsp_data[1]), 32'hEFFF);
    repeat (5) cyc();

    // Reset pulse with fetches in flight; memory contents survive.
    req_valid = 1'b1; req_addr = 16'h0032;
    cyc();
    req_addr = 16'h0000;
    cyc();
    req_valid = 1'b0; rst = 1'b0;
    cyc();
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      check("t6 valid after reset", 32'(rsp_valid[i]), 32'd0);
      check("t6 data after reset", 32'(rsp_data[i]), 32'd0);
    end
    req_valid = 1'b1; req_addr = 16'h0032;
    cyc();
    req_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check("t6 L4 no stale rsp", 32'(rsp_valid[2]), 32'd0);
      cyc();
    end
    check("t6 L4 retained word", 32'(rsp_data[2]), 32'hEFFF);
    repeat (5) cyc();

    // Randomized traffic with loads, stalls, flushes and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      ld_en     = ($urandom_range(0, 9) == 0);
      ld_addr   = pick_addr();
      ld_data   = DW'($urandom);
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = pick_addr();
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    rst = 1'b1; flush = 1'b0; ld_en = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (6) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
